// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl: decode/execute operands,
// memory handshake, and the stage enable/flush controls it returns.
interface hazard_ctrl_if #(
   parameter int REGW = 4
);
   logic [REGW-1:0] id_rs1;
   logic [REGW-1:0] id_rs2;
   logic            id_uses_rs2;
   logic [REGW-1:0] ex_rd;
   logic            ex_memread;
   logic            pc_select;
   logic            mem_req;
   logic            mem_ready;
   logic            pc_en;
   logic            ifid_en;
   logic            ifid_flush;
   logic            idex_en;
   logic            idex_flush;
   logic            exmem_en;
   logic            busy;
   logic            mem_timeout;
   logic [15:0]     stall_cnt;
   logic [15:0]     flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memread,
             pc_select, mem_req, mem_ready,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             busy, mem_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memread,
             pc_select, mem_req, mem_ready,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             busy, mem_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: load-use bubble, branch
// squash, memory-wait freeze with timeout. HAZARD_STATS_EN builds the stall/flush counters.
module hazard_ctrl #(
   parameter int REGW         = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 64,
   parameter int PC_REG       = 15
) (
   input logic          clk,
   input logic          reset,
   hazard_ctrl_if.slave hif
);
   // state      | meaning
   // S_RUN      | normal flow; only single-cycle load-use bubbles
   // S_MEM_WAIT | pipeline frozen until mem_ready or timeout
   // S_FLUSH    | IF/ID squashed for remaining post-branch cycles

   localparam int FW = $clog2(FLUSH_CYCLES + 1);
   localparam int WW = $clog2(MEM_TIMEOUT);
   localparam logic [REGW-1:0] PC_IDX = REGW'(PC_REG);
   localparam logic [FW-1:0]   F_LOAD = FW'(FLUSH_CYCLES - 1);
   localparam logic [WW-1:0]   W_LOAD = WW'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_FLUSH} state_t;

   state_t        state, state_nxt;
   logic [FW-1:0] fcnt, fcnt_nxt;
   logic [WW-1:0] wrem, wrem_nxt;
   logic          busy_q, timeout_q;
   logic          timeout_set, branch_taken, take_branch;
   logic          lu_hazard, mem_stall;
   logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;

   assign lu_hazard = hif.ex_memread && (hif.ex_rd != PC_IDX) &&
                      ((hif.ex_rd == hif.id_rs1) ||
                       (hif.id_uses_rs2 && (hif.ex_rd == hif.id_rs2)));
   assign mem_stall = hif.mem_req && !hif.mem_ready;

   always_comb begin
      state_nxt    = state;
      fcnt_nxt     = fcnt;
      wrem_nxt     = wrem;
      timeout_set  = 1'b0;
      take_branch  = 1'b0;
      branch_taken = 1'b0;
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      ifid_flush   = 1'b0;
      idex_en      = 1'b1;
      idex_flush   = 1'b0;
      exmem_en     = 1'b1;
      if (!reset) begin
         case (state)
            S_RUN, S_FLUSH: begin
               if (hif.pc_select) begin
                  take_branch = 1'b1;
               end else if (mem_stall) begin
                  {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                  state_nxt = S_MEM_WAIT;
                  wrem_nxt  = W_LOAD;
               end else begin
                  if (lu_hazard) begin
                     pc_en      = 1'b0;
                     ifid_en    = 1'b0;
                     idex_flush = 1'b1;
                  end
                  if (state == S_FLUSH) begin
                     ifid_flush = 1'b1;
                     fcnt_nxt   = fcnt - FW'(1);
                     if (fcnt == FW'(1))
                        state_nxt = S_RUN;
                  end
               end
            end
            S_MEM_WAIT: begin
               // terminal count doubles as a forced release
               if (hif.mem_ready || (wrem == '0)) begin
                  timeout_set = !hif.mem_ready;
                  state_nxt   = S_RUN;
                  take_branch = hif.pc_select;
               end else begin
                  {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                  wrem_nxt = wrem - WW'(1);
               end
            end
            default: state_nxt = S_RUN;
         endcase

         if (take_branch) begin
            branch_taken = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
               state_nxt = S_FLUSH;
               fcnt_nxt  = F_LOAD;
            end else begin
               state_nxt = S_RUN;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_RUN;
         fcnt      <= '0;
         wrem      <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         fcnt      <= fcnt_nxt;
         wrem      <= wrem_nxt;
         busy_q    <= (state_nxt != S_RUN);
         timeout_q <= timeout_q | timeout_set;
      end
   end

   assign hif.pc_en       = pc_en;
   assign hif.ifid_en     = ifid_en;
   assign hif.ifid_flush  = ifid_flush;
   assign hif.idex_en     = idex_en;
   assign hif.idex_flush  = idex_flush;
   assign hif.exmem_en    = exmem_en;
   assign hif.busy        = busy_q;
   assign hif.mem_timeout = timeout_q;

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_q, flush_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_en && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
         if (branch_taken && (flush_q != 16'hFFFF))
            flush_q <= flush_q + 16'd1;
      end
   end

   assign hif.stall_cnt = stall_q;
   assign hif.flush_cnt = flush_q;
`else
   assign hif.stall_cnt = '0;
   assign hif.flush_cnt = '0;
`endif
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage core. It sits beside the execute stage and drives the enable and flush controls of PC, IF/ID, ID/EX and EX/MEM. It produces three actions: a one-cycle bubble on load-use hazards, a multi-cycle IF/ID squash when the branch-condition unit redirects the PC, and a full-pipeline freeze while a data-memory access is outstanding, bounded by a timeout.

Parameters:
REGW, 4, register-index width
FLUSH_CYCLES, 2, cycles IF/ID is squashed after a taken branch (>=1)
MEM_TIMEOUT, 64, max freeze cycles waiting on mem_ready (>=2)
PC_REG, 15, register index excluded from hazard compare (PC)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
id_rs1  in  REGW  first source register of the instruction in decode
id_rs2  in  REGW  second source register of the instruction in decode
id_uses_rs2  in  1  0 when the decode instruction uses an immediate operand
ex_rd  in  REGW  destination register of the instruction in execute
ex_memread  in  1  the instruction in execute is a load
pc_select  in  1  taken-branch redirect from the condition unit
mem_req  in  1  data-memory access active in MEM
mem_ready  in  1  data memory completes this cycle
pc_en  out  1  PC write enable
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID squash; overrides ifid_en
idex_en  out  1  ID/EX enable
idex_flush  out  1  ID/EX bubble insert
exmem_en  out  1  EX/MEM enable
busy  out  1  state != RUN (registered)
mem_timeout  out  1  sticky, set when a wait expires
stall_cnt  out  16  stall-cycle statistic (see option)
flush_cnt  out  16  taken-branch statistic (see option)

Behaviour:
- FSM states: RUN, MEM_WAIT, FLUSH. Reset gives RUN, counters 0, mem_timeout 0, busy 0.
- Control outputs are combinational from state and inputs. Default: all enables 1, flushes 0.
- lu_hazard = ex_memread & ex_rd!=PC_REG & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
- mem_stall = mem_req & !mem_ready.
- Priority in RUN and FLUSH: pc_select > mem_stall > lu_hazard.
- pc_select=1: ifid_flush=1, idex_flush=1, pc_en=1.
  - Next state is FLUSH with fcnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1; otherwise RUN.
  - A new pc_select while in FLUSH reloads fcnt.
- mem_stall: pc_en, ifid_en, idex_en, exmem_en all 0; flushes 0. Next state MEM_WAIT, wcnt=1.
- lu_hazard: pc_en=0, ifid_en=0, idex_flush=1 (exactly one bubble).
  - State is unchanged; the bubble clears ex_memread on the next cycle, so no repeat stall.
- FLUSH, with no higher-priority event: ifid_flush=1 and fcnt decrements. At fcnt==1, next state is RUN.
  - mem_stall in FLUSH drops the remaining flush cycles and enters MEM_WAIT. IF/ID stays frozen on the already-squashed bubble.
- MEM_WAIT while !mem_ready: all enables 0; wcnt increments.
- MEM_WAIT with mem_ready=1: enables 1 this cycle (release), next state RUN.
  - pc_select in the same release cycle applies the taken-branch action and enters FLUSH.
  - lu_hazard is ignored in the release cycle and re-evaluated next cycle.
- MEM_WAIT timeout: when wcnt==MEM_TIMEOUT and !mem_ready, mem_timeout is set (sticky until reset) and the cycle is treated as a release.
- pc_select during MEM_WAIT before release is ignored; EX is frozen, so the condition unit re-presents it at release.
- busy = registered (state != RUN).
- Reset mid-operation: next edge forces RUN, clears counters and mem_timeout. Outputs in the reset cycle take the defaults.

Optional Feature:
HAZARD_STATS_EN:
- Defined: stall_cnt increments on every cycle with pc_en==0. flush_cnt increments on every cycle pc_select is acted on. Both are 16-bit, saturate at 0xFFFF, and clear on reset.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter logic is built.

Test Plan:
- Load-use: ex_memread=1, ex_rd=3, id_rs1=3 for one cycle -> that cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle (ex_memread=0) all defaults, busy stays 0.
- Immediate and PC exclusions: ex_rd=5=id_rs2, id_uses_rs2=0 -> no stall. Separately ex_rd=15=id_rs1 -> no stall.
- Taken branch, FLUSH_CYCLES=2: pc_select pulse at cycle t -> ifid_flush=1 at t and t+1, idex_flush=1 at t only, state RUN at t+2. With the option, flush_cnt=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> enables 0 for 3 cycles, 1 in the release cycle, busy=1 for 3 cycles, mem_timeout=0. With the option, stall_cnt=3.
- Timeout, MEM_TIMEOUT=4: mem_req=1, mem_ready=0 held -> freeze for 4 cycles then release; mem_timeout=1 remains set until reset.
- Simultaneous events: pc_select=1 with lu_hazard=1 -> flush action only, pc_en=1. Reset asserted in MEM_WAIT -> RUN and mem_timeout=0 after the edge.
